bram_matmul_ctrl: RTL and testbench
===================================

Name: bram_matmul_ctrl

Overview:
- BRAM master that sits directly upstream/downstream of the accelerator's 32-bit word BRAM, on the same port.
- Fetches a 4x4 signed 8-bit matrix A and a 4x4 signed 8-bit matrix B from the BRAM, computes C = A x B with 32-bit signed elements, and writes C back into the same BRAM.
- Raises done when all results are written, which triggers the memory dump in simulation.

Parameters:
- BRAM_ADDR_WIDTH, 15, byte-address width driven to the BRAM; word index = BRAM_ADDR[BRAM_ADDR_WIDTH-1:2].
- A_BASE, 0, word index of A row 0 (rows at A_BASE..A_BASE+3).
- B_BASE, 4, word index of B row 0 (rows at B_BASE..B_BASE+3).
- C_BASE, 8, word index of C[0][0] (C[i][j] at C_BASE+4*i+j).
- READ_HOLD, 2, cycles EN is held high with WE=0 on one address per read.

Ports:
- BRAM_CLK  input  1  single clock for controller and BRAM.
- BRAM_RST  input  1  synchronous, active-high reset.
- start  input  1  level; launches a run when sampled high in IDLE or DONE.
- BRAM_ADDR  output  BRAM_ADDR_WIDTH  byte address = {word_index, 2'b00}.
- BRAM_WRDATA  output  32  write data; 0 when not writing.
- BRAM_RDDATA  input  32  read data from BRAM.
- BRAM_EN  output  1  BRAM enable.
- BRAM_WE  output  4  byte write enables; 4'hF on write cycles, else 0.
- busy  output  1  high in LOAD and WRITE.
- done  output  1  high in DONE.

Behaviour:
- Reset (synchronous, BRAM_RST=1 at a clock edge):
  - state=IDLE.
  - BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_EN=0, BRAM_WE=0, busy=0, done=0.
  - Row registers cleared.
  - Reset wins over every other condition.
- Data format:
  - A row i word: byte k ([8k+7:8k]) = A[i][k].
  - B row k word: byte j = B[k][j].
  - All elements are signed two's complement.
- Arithmetic: C[i][j] = sum over k of A[i][k]*B[k][j].
  - Products are 16-bit signed; the sum is sign-extended to 32 bits.
  - No overflow is possible (|C| <= 65536).
- IDLE: all outputs at their reset values. start=1 -> LOAD, word counter w=0.
- LOAD, 8 word reads, w=0..7: w<4 reads A_BASE+w, w>=4 reads B_BASE+w-4. Each read takes READ_HOLD+1 cycles:
  - READ_HOLD cycles with EN=1, WE=0, and the address stable.
  - Then one cycle with EN=0, during which BRAM_RDDATA is registered into row register w.
  - After w=7 is captured -> WRITE with element index e=0.
- WRITE, 16 cycles, e=0..15, one element per cycle (i=e[3:2], j=e[1:0]):
  - EN=1, WE=4'hF, address C_BASE+e, WRDATA=C[i][j], computed combinationally from the row registers.
  - After e=15 -> DONE.
- DONE: done=1, EN=0, WE=0; done is held while start=0. start=1 -> LOAD, and done drops on that same edge.
- start during LOAD/WRITE is ignored; it never restarts or extends a run.
- Latency: done is first high (1 + 8*(READ_HOLD+1) + 16) cycles after the edge that samples start. With defaults this is 41.
- Reset mid-run:
  - State returns to IDLE on that edge; EN and WE are 0 from then on.
  - No further BRAM writes occur. Already-written C words remain; unwritten ones are untouched.
- Address wrap: word_index is truncated to BRAM_ADDR_WIDTH-2 bits; bases are the user's responsibility.
- BRAM_ADDR holds its last value outside LOAD/WRITE, except after reset, when it is 0.

Test Plan:
- Run with A=identity (rows 0x00000001, 0x00000100, 0x00010000, 0x01000000) and B rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D -> C words 8..23 = 1..16 in order, each written as 0x000000NN.
- Run with all A and B bytes 0x80 (-128) -> all 16 C words = 0x00010000; all A bytes 0x7F with all B bytes 0x80 -> all = 0xFFFF0200 (-65024).
- Latency with defaults -> done rises exactly 41 cycles after start is sampled.
  - EN pattern during LOAD is (1,1,0) repeated 8 times.
  - BRAM_ADDR during LOAD is bytes 0,4,...,28.
  - WE=4'hF for exactly 16 cycles, at addresses 32..92.
- Pulse start again at cycle 10 of a run -> no restart; done still rises at cycle 41 and the result is identical.
- Assert BRAM_RST after the 5th write cycle -> C words 8..12 written, words 13..23 keep their preload pattern, done=0, EN=0 next cycle.
- Hold start=1 in DONE -> a second run begins; done low for 41 cycles, then high; C is rewritten with the same values.

Source files
------------

// File: rtl/bram_matmul_ctrl.sv
// bram_matmul_ctrl: BRAM master that reads a 4x4 int8 matrix A and a 4x4 int8
// matrix B from a 32-bit word BRAM, computes C = A x B as 32-bit signed words
// and writes the 16 results back to the same BRAM, then raises done.
module bram_matmul_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int A_BASE          = 0,
    parameter int B_BASE          = 4,
    parameter int C_BASE          = 8,
    parameter int READ_HOLD       = 2
) (
    input  logic                       BRAM_CLK,
    input  logic                       BRAM_RST,
    input  logic                       start,
    output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [31:0]                BRAM_WRDATA,
    input  logic [31:0]                BRAM_RDDATA,
    output logic                       BRAM_EN,
    output logic [3:0]                 BRAM_WE,
    output logic                       busy,
    output logic                       done
);

    // Word index width; the two low byte-address bits are always zero.
    localparam int WIDX_W = BRAM_ADDR_WIDTH - 2;
    // Phase counter covers READ_HOLD enable cycles plus the capture cycle.
    localparam int PH_W = $clog2(READ_HOLD + 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(READ_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [2:0]        word_reg;    // row register currently being read
    logic [PH_W-1:0]   phase_reg;   // position inside one read slot
    logic              prime_reg;   // first LOAD cycle: nothing to capture yet
    logic [3:0]        elem_reg;    // C element being written
    logic [31:0]       row_reg [0:7]; // rows 0..3 = A, rows 4..7 = B

    logic [2:0]        word_next;
    logic [1:0]        ci;
    logic [1:0]        cj;
    logic [31:0]       a_word;
    logic [15:0]       prod [0:3];
    logic [17:0]       sum_ext;
    logic [31:0]       c_elem;

    // Byte address of a word index; the index silently wraps to WIDX_W bits.
    function automatic logic [BRAM_ADDR_WIDTH-1:0] byte_addr(input logic [31:0] word);
        return {word[WIDX_W-1:0], 2'b00};
    endfunction

    // Word index of the w-th fetched row: A rows first, then B rows.
    function automatic logic [31:0] read_word(input logic [2:0] w);
        if (!w[2]) begin
            return 32'(A_BASE) + {30'd0, w[1:0]};
        end
        return 32'(B_BASE) + {30'd0, w[1:0]};
    endfunction

    // Next row to fetch: the priming cycle starts at row 0 without advancing.
    always_comb begin
        word_next = word_reg;
        if (!prime_reg) begin
            word_next = word_reg + 3'd1;
        end
    end

    // Element coordinates of the current write and the matching A row word.
    assign ci     = elem_reg[3:2];
    assign cj     = elem_reg[1:0];
    assign a_word = row_reg[{1'b0, ci}];

    // One signed 8x8 product per k term of the dot product A[i][k]*B[k][j].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mac
            logic [31:0]       b_word;
            logic signed [7:0] a_byte;
            logic signed [7:0] b_byte;
            assign b_word  = row_reg[3'(4 + gi)];
            assign a_byte  = a_word[8*gi +: 8];
            assign b_byte  = b_word[{cj, 3'b000} +: 8];
            assign prod[gi] = 16'(a_byte * b_byte);
        end
    endgenerate

    // Sign-extended sum of the four products; 18 bits cannot overflow.
    assign sum_ext = {{2{prod[0][15]}}, prod[0]} + {{2{prod[1][15]}}, prod[1]}
                   + {{2{prod[2][15]}}, prod[2]} + {{2{prod[3][15]}}, prod[3]};
    assign c_elem  = {{14{sum_ext[17]}}, sum_ext};

    // Write data is driven only while writing, so the last captured B row
    // feeds the very first write cycle without an extra pipeline stage.
    assign BRAM_WRDATA = (state_reg == S_WRITE) ? c_elem : 32'd0;

    // Controller FSM with registered BRAM controls and status outputs.
    always_ff @(posedge BRAM_CLK) begin
        if (BRAM_RST) begin
            state_reg <= S_IDLE;
            word_reg  <= 3'd0;
            phase_reg <= '0;
            prime_reg <= 1'b0;
            elem_reg  <= 4'd0;
            BRAM_ADDR <= '0;
            BRAM_EN   <= 1'b0;
            BRAM_WE   <= 4'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                row_reg[r] <= 32'd0;
            end
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Spend one priming cycle before the first read slot.
                        state_reg <= S_LOAD;
                        word_reg  <= 3'd0;
                        phase_reg <= PH_LAST;
                        prime_reg <= 1'b1;
                        BRAM_EN   <= 1'b0;
                        BRAM_WE   <= 4'h0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (phase_reg != PH_LAST) begin
                        // Hold the address with EN high for READ_HOLD cycles.
                        phase_reg <= phase_reg + PH_W'(1);
                        BRAM_EN   <= ((phase_reg + PH_W'(1)) != PH_LAST);
                    end else begin
                        // EN-low cycle: read data has settled, capture it.
                        if (!prime_reg) begin
                            row_reg[word_reg] <= BRAM_RDDATA;
                        end
                        if (!prime_reg && (word_reg == 3'd7)) begin
                            state_reg <= S_WRITE;
                            elem_reg  <= 4'd0;
                            BRAM_ADDR <= byte_addr(32'(C_BASE));
                            BRAM_EN   <= 1'b1;
                            BRAM_WE   <= 4'hF;
                        end else begin
                            word_reg  <= word_next;
                            phase_reg <= '0;
                            prime_reg <= 1'b0;
                            BRAM_ADDR <= byte_addr(read_word(word_next));
                            BRAM_EN   <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    if (elem_reg == 4'd15) begin
                        state_reg <= S_DONE;
                        BRAM_EN   <= 1'b0;
                        BRAM_WE   <= 4'h0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        elem_reg  <= elem_reg + 4'd1;
                        BRAM_ADDR <= byte_addr(32'(C_BASE) + {28'd0, elem_reg} + 32'd1);
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_matmul_ctrl.sv
// Self-checking bench for bram_matmul_ctrl: a behavioural BRAM plus an
// arithmetic reference for C = A x B, directed corner runs and random runs.
module tb_bram_matmul_ctrl;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wrdata;
    logic [31:0]   bram_rddata;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic          busy;
    logic          done;

    // Bench-side preload port into the memory model.
    logic          tb_we;
    logic [12:0]   tb_addr;
    logic [31:0]   tb_data;

    logic [31:0]   mem [0:8191];
    logic [31:0]   a_mat [4];
    logic [31:0]   b_mat [4];
    logic [31:0]   exp_c [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bram_matmul_ctrl dut (
        .BRAM_CLK    (clk),
        .BRAM_RST    (rst),
        .start       (start),
        .BRAM_ADDR   (bram_addr),
        .BRAM_WRDATA (bram_wrdata),
        .BRAM_RDDATA (bram_rddata),
        .BRAM_EN     (bram_en),
        .BRAM_WE     (bram_we),
        .busy        (busy),
        .done        (done)
    );

    // Read-first single-port BRAM with one cycle read latency.
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (bram_en) begin
            if (bram_we == 4'hF) begin
                mem[bram_addr[AW-1:2]] <= bram_wrdata;
            end
            bram_rddata <= mem[bram_addr[AW-1:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference element: plain signed dot product of bytes.
    function automatic logic [31:0] ref_c(input int i, input int j);
        int s;
        logic [31:0] aw;
        logic [31:0] bw;
        s = 0;
        aw = a_mat[i];
        for (int k = 0; k < 4; k++) begin
            bw = b_mat[k];
            s += int'($signed(aw[8*k +: 8])) * int'($signed(bw[8*j +: 8]));
        end
        return 32'(s);
    endfunction

    function automatic logic [31:0] preload_word(input int c);
        return 32'hA5A5_0000 | 32'(c);
    endfunction

    task automatic mem_put(input int idx, input logic [31:0] d);
        tb_we   = 1'b1;
        tb_addr = 13'(idx);
        tb_data = d;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // One run: preload, pulse start, watch every cycle, then check memory.
    // pulse_at > 0 re-asserts start for one cycle mid-run; rst_after > 0
    // resets the controller right after that many write cycles.
    task automatic do_run(input string name, input int pulse_at, input int rst_after);
        logic [24:0] en_vec;
        logic [24:0] en_exp;
        int cyc;
        int wr_cnt;
        int done_cyc;
        int stray;
        int n_expected_wr;
        bit stop;
        for (int w = 0; w < 4; w++) begin
            mem_put(w, a_mat[w]);
            mem_put(4 + w, b_mat[w]);
        end
        for (int c = 0; c < 16; c++) begin
            mem_put(8 + c, preload_word(c));
            exp_c[c] = ref_c(c / 4, c % 4);
        end
        en_exp = '0;
        for (int c = 1; c <= 25; c++) begin
            en_exp[25 - c] = (c >= 2) && (((c - 2) % 3) != 2);
        end
        en_vec = '0;
        wr_cnt = 0;
        done_cyc = 0;
        stray = 0;
        stop = 0;
        cyc = 0;
        start = 1'b1;
        while (!stop && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (pulse_at > 0 && cyc == pulse_at) start = 1'b1;
            if (pulse_at > 0 && cyc == pulse_at + 1) start = 1'b0;
            if (cyc <= 25) begin
                en_vec[25 - cyc] = bram_en;
                if (cyc >= 2 && ((cyc - 2) % 3) == 0) begin
                    check("load_addr", 32'(bram_addr), 32'(4 * ((cyc - 2) / 3)));
                end
            end
            if (bram_we != 4'h0) begin
                check("wr_we", {28'd0, bram_we}, 32'hF);
                check("wr_addr", 32'(bram_addr), 32'(4 * (8 + wr_cnt)));
                check("wr_data", bram_wrdata, exp_c[wr_cnt % 16]);
                wr_cnt++;
            end else if (bram_wrdata != 32'd0) begin
                stray++;
            end
            if (rst_after > 0 && wr_cnt == rst_after && !rst) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_en", {31'd0, bram_en}, 32'd0);
                check("rst_we", {28'd0, bram_we}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_idle_en", {31'd0, bram_en}, 32'd0);
                stop = 1;
            end else if (done) begin
                done_cyc = cyc;
                stop = 1;
            end
        end
        check("en_pattern", 32'(en_vec), 32'(en_exp));
        check("wrdata_idle_zero", 32'(stray), 32'd0);
        if (rst_after > 0) begin
            n_expected_wr = rst_after;
        end else begin
            n_expected_wr = 16;
            check("done_latency", 32'(done_cyc - 1), 32'd41);
            check("write_count", 32'(wr_cnt), 32'd16);
            check("busy_at_done", {31'd0, busy}, 32'd0);
            repeat (3) @(negedge clk);
            check("done_held", {31'd0, done}, 32'd1);
            check("done_en_low", {31'd0, bram_en}, 32'd0);
        end
        for (int c = 0; c < 16; c++) begin
            check("c_word", mem[8 + c], (c < n_expected_wr) ? exp_c[c] : preload_word(c));
        end
        $display("run %s: done_cycle=%0d writes=%0d checks=%0d errors=%0d",
                 name, done_cyc, wr_cnt, n_checks, n_errors);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tb_we = 1'b0;
        tb_addr = '0;
        tb_data = '0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_wrdata", bram_wrdata, 32'd0);
        check("rst_en0", {31'd0, bram_en}, 32'd0);
        check("rst_we0", {28'd0, bram_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done0", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Identity A: C equals B, i.e. words 8..23 hold 1..16.
        a_mat = '{32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000};
        b_mat = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
        do_run("identity", 0, 0);
        check("ident_first", mem[8], 32'd1);
        check("ident_last", mem[23], 32'd16);

        // Extreme negative times extreme negative.
        a_mat = '{4{32'h8080_8080}};
        b_mat = '{4{32'h8080_8080}};
        do_run("neg_neg", 0, 0);
        check("negneg_word", mem[8], 32'h0001_0000);

        // Extreme positive times extreme negative.
        a_mat = '{4{32'h7F7F_7F7F}};
        do_run("pos_neg", 0, 0);
        check("posneg_word", mem[23], 32'hFFFF_0200);

        // Start pulse mid-run must neither restart nor stretch the run.
        a_mat = '{32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000};
        b_mat = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
        do_run("pulse10", 10, 0);

        // Random matrices, some with a random stray start pulse.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 4; w++) begin
                a_mat[w] = $urandom;
                b_mat[w] = $urandom;
            end
            do_run("random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0, 0);
        end

        // Reset right after the fifth write cycle.
        for (int w = 0; w < 4; w++) begin
            a_mat[w] = $urandom;
            b_mat[w] = $urandom;
        end
        do_run("reset_mid", 0, 5);

        // Back-to-back runs: the second one launched from DONE.
        do_run("from_idle", 0, 0);
        do_run("from_done", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
